// File: rtl/slot_alloc_if.sv
// slot_alloc_if: allocate/free handshake and occupancy bundle for slot_alloc.
// With SLOT_ALLOC_ERR_EN defined the bundle also carries the sticky o_err flag.
interface slot_alloc_if #(
    parameter int W = 16
);
    localparam int IW = $clog2(W);

    logic          i_alloc_req;
    logic          o_alloc_vld;
    logic [IW-1:0] o_alloc_idx;
    logic          i_free_vld;
    logic [IW-1:0] i_free_idx;
    logic [W-1:0]  o_busy;
    logic [IW:0]   o_cnt;
    logic          o_full;
    logic          o_empty;
`ifdef SLOT_ALLOC_ERR_EN
    logic          o_err;
`endif

    // allocator side
    modport slave (
        input  i_alloc_req, i_free_vld, i_free_idx,
        output o_alloc_vld, o_alloc_idx, o_busy, o_cnt,
`ifdef SLOT_ALLOC_ERR_EN
        output o_err,
`endif
        output o_full, o_empty
    );

    // consumer / producer side
    modport master (
        output i_alloc_req, i_free_vld, i_free_idx,
        input  o_alloc_vld, o_alloc_idx, o_busy, o_cnt,
`ifdef SLOT_ALLOC_ERR_EN
        input  o_err,
`endif
        input  o_full, o_empty
    );
endinterface

// File: rtl/slot_alloc.sv
// slot_alloc: lowest-free-first slot allocator with registered occupancy.
// Optional SLOT_ALLOC_ERR_EN adds sticky o_err and simulation assertions.
module slot_alloc #(
    parameter int W = 16
) (
    input  logic        clk,
    input  logic        arst_n,
    slot_alloc_if.slave bus
);
    localparam int IW = $clog2(W);

    logic [W-1:0]  busy_r;
    logic [W-1:0]  busy_nxt;
    logic [W-1:0]  alloc_oh;
    logic [W-1:0]  free_oh;
    logic [IW:0]   cnt_r;
    logic [IW:0]   cnt_nxt;
    logic          vld_r;
    logic          vld_nxt;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] idx_nxt;
    logic          full_r;
    logic          empty_r;
    logic          alloc_fire;
    logic          free_fire;

    // Next occupancy, count and lowest-free presentation.
    // A free only matches a busy in-range slot, so bad frees drop out here.
    always_comb begin
        alloc_oh   = '0;
        free_oh    = '0;
        alloc_fire = bus.i_alloc_req & vld_r;
        for (int i = 0; i < W; i++) begin
            alloc_oh[i] = alloc_fire && (idx_r == IW'(i));
            free_oh[i]  = bus.i_free_vld && (bus.i_free_idx == IW'(i))
                          && busy_r[i];
        end
        free_fire = |free_oh;
        busy_nxt  = (busy_r | alloc_oh) & ~free_oh;
        cnt_nxt   = cnt_r + {{IW{1'b0}}, alloc_fire}
                          - {{IW{1'b0}}, free_fire};
        vld_nxt   = ~&busy_nxt;
        idx_nxt   = idx_r;
        for (int i = W - 1; i >= 0; i--) begin
            if (!busy_nxt[i]) idx_nxt = IW'(i);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_r  <= '0;
            cnt_r   <= '0;
            vld_r   <= 1'b1;
            idx_r   <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            busy_r  <= busy_nxt;
            cnt_r   <= cnt_nxt;
            vld_r   <= vld_nxt;
            idx_r   <= idx_nxt;
            full_r  <= (cnt_nxt == (IW+1)'(W));
            empty_r <= (cnt_nxt == '0);
        end
    end

    assign bus.o_busy      = busy_r;
    assign bus.o_cnt       = cnt_r;
    assign bus.o_alloc_vld = vld_r;
    assign bus.o_alloc_idx = idx_r;
    assign bus.o_full      = full_r;
    assign bus.o_empty     = empty_r;

`ifdef SLOT_ALLOC_ERR_EN
    logic err_r;
    logic bad_free;
    logic bad_alloc;

    assign bad_free  = bus.i_free_vld & ~free_fire;
    assign bad_alloc = bus.i_alloc_req & ~vld_r;

    // Sticky flag for any dropped request.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) err_r <= 1'b0;
        else         err_r <= err_r | bad_free | bad_alloc;
    end

    assign bus.o_err = err_r;

    // Flag dropped requests and check occupancy consistency.
    always @(posedge clk) begin
        if (arst_n) begin
            assert (!bad_free)
                else $warning("slot_alloc: free of idle or bad slot");
            assert (!bad_alloc)
                else $warning("slot_alloc: alloc while none presented");
            assert ($countones(busy_r) == int'(cnt_r))
                else $error("slot_alloc: count out of sync with busy map");
        end
    end
`endif

endmodule

// File: tb/tb_slot_alloc.sv
// tb_slot_alloc: table vectors, hand sequences and a random model run.
// Expected results go through a scoreboard queue and are checked after each edge.
module tb_slot_alloc;
    localparam int W = 4;

    typedef struct packed {
        logic [3:0] busy;
        logic [2:0] cnt;
        logic       vld;
        logic [1:0] idx;
        logic       full;
        logic       empty;
    } exp_t;

    typedef struct packed {
        logic       a;
        logic       fv;
        logic [1:0] fi;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sbq[$];
    vec_t vecs[$];

    bit [3:0] m_busy;
    int       m_cnt;
    bit       m_vld;
    int       m_idx;

    slot_alloc_if #(.W(W)) bus ();

    slot_alloc #(.W(W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h", nm, act, req);
        end
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, " busy"}, 32'(bus.o_busy), 32'(e.busy));
        chk({tag, " cnt"}, 32'(bus.o_cnt), 32'(e.cnt));
        chk({tag, " vld"}, 32'(bus.o_alloc_vld), 32'(e.vld));
        chk({tag, " idx"}, 32'(bus.o_alloc_idx), 32'(e.idx));
        chk({tag, " full"}, 32'(bus.o_full), 32'(e.full));
        chk({tag, " empty"}, 32'(bus.o_empty), 32'(e.empty));
    endtask

    function automatic exp_t mk(input logic [3:0] b, input int c,
                                input bit v, input int ix,
                                input bit fu, input bit em);
        exp_t e;
        e.busy  = b;
        e.cnt   = 3'(c);
        e.vld   = v;
        e.idx   = 2'(ix);
        e.full  = fu;
        e.empty = em;
        return e;
    endfunction

    function automatic vec_t mkv(input bit a, input bit fv, input int fi,
                                 input exp_t e);
        vec_t v;
        v.a  = a;
        v.fv = fv;
        v.fi = 2'(fi);
        v.e  = e;
        return v;
    endfunction

    // Reference model: apply one cycle of requests, return expected outputs.
    function automatic exp_t model(input bit a, input bit fv, input int fi);
        bit af;
        bit ff;
        af = a && m_vld;
        ff = fv && fi < W && m_busy[fi];
        if (ff) m_busy[fi] = 1'b0;
        if (af) m_busy[m_idx] = 1'b1;
        m_cnt = m_cnt + int'(af) - int'(ff);
        m_vld = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!m_vld && !m_busy[i]) begin
                m_vld = 1'b1;
                m_idx = i;
            end
        end
        return mk(m_busy, m_cnt, m_vld, m_idx, m_cnt == W, m_cnt == 0);
    endfunction

    task automatic step(input string tag, input logic a, input logic fv,
                        input logic [1:0] fi, input exp_t e);
        exp_t got;
        @(negedge clk);
        bus.i_alloc_req = a;
        bus.i_free_vld  = fv;
        bus.i_free_idx  = fi;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        cmp_out(tag, got);
        if (bus.o_alloc_vld)
            chk({tag, " presented busy"},
                32'(bus.o_busy[bus.o_alloc_idx]), 32'd0);
        chk({tag, " popcount"}, $countones(bus.o_busy), 32'(bus.o_cnt));
    endtask

    initial begin
        bus.i_alloc_req = 1'b0;
        bus.i_free_vld  = 1'b0;
        bus.i_free_idx  = '0;

        vecs.push_back(mkv(1, 0, 0, mk(4'b0001, 1, 1, 1, 0, 0)));
        vecs.push_back(mkv(1, 0, 0, mk(4'b0011, 2, 1, 2, 0, 0)));
        vecs.push_back(mkv(1, 0, 0, mk(4'b0111, 3, 1, 3, 0, 0)));
        vecs.push_back(mkv(1, 0, 0, mk(4'b1111, 4, 0, 3, 1, 0)));
        vecs.push_back(mkv(1, 0, 0, mk(4'b1111, 4, 0, 3, 1, 0)));
        vecs.push_back(mkv(0, 1, 2, mk(4'b1011, 3, 1, 2, 0, 0)));
        vecs.push_back(mkv(1, 0, 0, mk(4'b1111, 4, 0, 2, 1, 0)));
        vecs.push_back(mkv(0, 1, 0, mk(4'b1110, 3, 1, 0, 0, 0)));
        vecs.push_back(mkv(0, 1, 1, mk(4'b1100, 2, 1, 0, 0, 0)));
        vecs.push_back(mkv(1, 1, 3, mk(4'b0101, 2, 1, 1, 0, 0)));
        vecs.push_back(mkv(0, 1, 0, mk(4'b0100, 1, 1, 0, 0, 0)));
        vecs.push_back(mkv(0, 1, 2, mk(4'b0000, 0, 1, 0, 0, 1)));
        vecs.push_back(mkv(0, 1, 1, mk(4'b0000, 0, 1, 0, 0, 1)));
        vecs.push_back(mkv(1, 0, 0, mk(4'b0001, 1, 1, 1, 0, 0)));
        vecs.push_back(mkv(1, 0, 0, mk(4'b0011, 2, 1, 2, 0, 0)));
        vecs.push_back(mkv(1, 1, 0, mk(4'b0110, 2, 1, 0, 0, 0)));
        vecs.push_back(mkv(0, 1, 1, mk(4'b0100, 1, 1, 0, 0, 0)));
        vecs.push_back(mkv(0, 1, 2, mk(4'b0000, 0, 1, 0, 0, 1)));
        vecs.push_back(mkv(1, 0, 0, mk(4'b0001, 1, 1, 1, 0, 0)));
        vecs.push_back(mkv(0, 1, 3, mk(4'b0001, 1, 1, 1, 0, 0)));
        vecs.push_back(mkv(1, 0, 0, mk(4'b0011, 2, 1, 2, 0, 0)));
        vecs.push_back(mkv(1, 0, 0, mk(4'b0111, 3, 1, 3, 0, 0)));

        // Power-on reset state.
        repeat (2) @(negedge clk);
        cmp_out("reset", mk(4'b0000, 0, 1, 0, 0, 1));
`ifdef SLOT_ALLOC_ERR_EN
        chk("reset err", 32'(bus.o_err), 32'd0);
`endif
        arst_n = 1'b1;

        foreach (vecs[k])
            step($sformatf("vec%0d", k), vecs[k].a, vecs[k].fv,
                 vecs[k].fi, vecs[k].e);
`ifdef SLOT_ALLOC_ERR_EN
        chk("sticky err", 32'(bus.o_err), 32'd1);
`endif

        // Asynchronous reset mid-cycle with an alloc in flight.
        bus.i_alloc_req = 1'b1;
        #2;
        arst_n = 1'b0;
        #1;
        cmp_out("async rst", mk(4'b0000, 0, 1, 0, 0, 1));
`ifdef SLOT_ALLOC_ERR_EN
        chk("async rst err", 32'(bus.o_err), 32'd0);
`endif
        @(posedge clk);
        #1;
        cmp_out("rst held", mk(4'b0000, 0, 1, 0, 0, 1));
        bus.i_alloc_req = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;

        m_busy = '0;
        m_cnt  = 0;
        m_vld  = 1'b1;
        m_idx  = 0;
        step("post rst", 1'b1, 1'b0, 2'd0, model(1'b1, 1'b0, 0));

        // Random traffic against the reference model.
        for (int c = 0; c < 10000; c++) begin
            bit a;
            bit fv;
            int fi;
            a  = ($urandom_range(0, 99) < 55);
            fv = ($urandom_range(0, 99) < 50);
            fi = int'($urandom_range(0, W - 1));
            step("rand", a, fv, 2'(fi), model(a, fv, fi));
        end

        chk("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
